// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback constants, types and the busy-with-bypass helper.
package wb_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [AW-1:0] regidx_t;

    typedef struct packed {
        logic            int_we;
        logic            fp_we;
        regidx_t         waddr;
        logic [XLEN-1:0] int_wdata;
        logic [XLEN-1:0] fp_wdata;
    } wb_write_t;

    function automatic logic busy(input logic [NREGS-1:0] pend, input logic [NREGS-1:0] clr, input regidx_t a);
        return pend[a] & ~clr[a];
    endfunction
endpackage

// File: rtl/wb_regfile_sink_rf_bank.sv
// rf_bank: one register array with NP write-first bypassed read ports and optional hardwired r0.
module rf_bank
    import wb_pkg::*;
#(
    parameter int NP      = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  regidx_t                  waddr,
    input  logic [XLEN-1:0]          wdata,
    input  regidx_t [NP-1:0]         raddr,
    output logic [NP-1:0][XLEN-1:0]  rdata
);
    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && !(ZERO_R0 && waddr == '0)) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_rd
        assign rdata[p] = (rst || (ZERO_R0 && raddr[p] == '0)) ? '0 :
                          (we && waddr == raddr[p])           ? wdata : mem[raddr[p]];
    end
endmodule

// File: rtl/wb_regfile_sink.sv
// wb_regfile_sink: int/fp register files fed by writeback, with an issue-set/writeback-clear
// pending scoreboard for RAW/WAW detection in decode.
module wb_regfile_sink
    import wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_int_we,
    input  logic            wb_fp_we,
    input  regidx_t         wb_waddr,
    input  logic [XLEN-1:0] wb_int_wdata,
    input  logic [XLEN-1:0] wb_fp_wdata,
    input  regidx_t         rs1_addr,
    input  regidx_t         rs2_addr,
    input  regidx_t         rs3_addr,
    output logic [XLEN-1:0] int_rs1_data,
    output logic [XLEN-1:0] int_rs2_data,
    output logic [XLEN-1:0] fp_rs1_data,
    output logic [XLEN-1:0] fp_rs2_data,
    output logic [XLEN-1:0] fp_rs3_data,
    input  logic            iss_valid,
    input  regidx_t         iss_rd,
    input  logic            iss_int_we,
    input  logic            iss_fp_we,
    output logic            int_rs1_busy,
    output logic            int_rs2_busy,
    output logic            fp_rs1_busy,
    output logic            fp_rs2_busy,
    output logic            fp_rs3_busy,
    output logic            rd_busy
);
    wb_write_t        wb;
    logic [NREGS-1:0] int_pend, fp_pend, int_set, fp_set, int_clr, fp_clr;

    assign wb = '{int_we: wb_int_we, fp_we: wb_fp_we, waddr: wb_waddr,
                  int_wdata: wb_int_wdata, fp_wdata: wb_fp_wdata};

    rf_bank #(.NP(2), .ZERO_R0(1'b1)) u_int (
        .clk(clk), .rst(rst), .we(wb.int_we), .waddr(wb.waddr), .wdata(wb.int_wdata),
        .raddr({rs2_addr, rs1_addr}), .rdata({int_rs2_data, int_rs1_data})
    );

    rf_bank #(.NP(3), .ZERO_R0(1'b0)) u_fp (
        .clk(clk), .rst(rst), .we(wb.fp_we), .waddr(wb.waddr), .wdata(wb.fp_wdata),
        .raddr({rs3_addr, rs2_addr, rs1_addr}), .rdata({fp_rs3_data, fp_rs2_data, fp_rs1_data})
    );

    always_comb begin
        int_set = (iss_valid && iss_int_we && iss_rd != '0) ? NREGS'(1) << iss_rd : '0;
        fp_set  = (iss_valid && iss_fp_we) ? NREGS'(1) << iss_rd : '0;
        int_clr = wb.int_we ? NREGS'(1) << wb.waddr : '0;
        fp_clr  = wb.fp_we ? NREGS'(1) << wb.waddr : '0;
    end

    // set is ORed after the clear so a same-cycle issue to the clearing index wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_pend <= '0;
            fp_pend  <= '0;
        end else begin
            int_pend <= (int_pend & ~int_clr) | int_set;
            fp_pend  <= (fp_pend & ~fp_clr) | fp_set;
        end
    end

    assign int_rs1_busy = busy(int_pend, int_clr, rs1_addr);
    assign int_rs2_busy = busy(int_pend, int_clr, rs2_addr);
    assign fp_rs1_busy  = busy(fp_pend, fp_clr, rs1_addr);
    assign fp_rs2_busy  = busy(fp_pend, fp_clr, rs2_addr);
    assign fp_rs3_busy  = busy(fp_pend, fp_clr, rs3_addr);
    assign rd_busy      = (iss_int_we & busy(int_pend, int_clr, iss_rd)) |
                          (iss_fp_we & busy(fp_pend, fp_clr, iss_rd));
endmodule
